// File: rtl/slot_event_detector_pkg.sv
// Shared definitions for the parking-slot event detector: slot count,
// default debounce length, per-slot state encoding and a popcount helper.
package slot_event_detector_pkg;

    localparam int NUM_SLOTS               = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_EMPTY       = 2'd0,
        ST_CONFIRM_IN  = 2'd1,
        ST_OCCUPIED    = 2'd2,
        ST_CONFIRM_OUT = 2'd3
    } slot_state_e;

    function automatic logic [2:0] popcount4(input logic [NUM_SLOTS-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/slot_event_detector_if.sv
// Bundle of the detector's sensor input and event/status outputs.
// master drives the raw sensors; slave is the detector side.
interface slot_event_detector_if;
    import slot_event_detector_pkg::*;

    logic [NUM_SLOTS-1:0]   slot_sensor;
    logic [NUM_SLOTS-1:0]   car_entry;
    logic [NUM_SLOTS-1:0]   car_exit;
    logic [NUM_SLOTS-1:0]   occupied;
    logic [2:0]             free_count;
    logic                   lot_full;
    logic [15:0]            entry_total;
    logic [2*NUM_SLOTS-1:0] dbg_state;

    modport master (
        output slot_sensor,
        input  car_entry, car_exit, occupied, free_count, lot_full, entry_total, dbg_state
    );

    modport slave (
        input  slot_sensor,
        output car_entry, car_exit, occupied, free_count, lot_full, entry_total, dbg_state
    );

endinterface

// File: rtl/slot_debounce_fsm.sv
// One slot: 2-flop synchronizer, debounce counter and FSM, with registered
// one-cycle entry/exit pulses on confirmed occupancy changes.
module slot_debounce_fsm
    import slot_event_detector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_i,
    output logic       entry_o,
    output logic       exit_o,
    output logic       occupied_o,
    output logic       occupied_d_o,
    output logic [1:0] state_o
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s_sync;
    slot_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             entry_q, entry_d;
    logic             exit_q, exit_d;

    assign s_sync = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], sensor_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            entry_q <= entry_d;
            exit_q  <= exit_d;
        end
    end

    // The counter holds the number of consecutive agreeing samples seen so far.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (s_sync) begin
                    state_d = ST_CONFIRM_IN;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CONFIRM_IN: begin
                if (!s_sync) begin
                    state_d = ST_EMPTY;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_OCCUPIED;
                    cnt_d   = '0;
                    entry_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_OCCUPIED: begin
                if (!s_sync) begin
                    state_d = ST_CONFIRM_OUT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CONFIRM_OUT: begin
                if (s_sync) begin
                    state_d = ST_OCCUPIED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_EMPTY;
                    cnt_d   = '0;
                    exit_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                cnt_d   = '0;
            end
        endcase
    end

    assign entry_o      = entry_q;
    assign exit_o       = exit_q;
    assign occupied_o   = (state_q == ST_OCCUPIED) || (state_q == ST_CONFIRM_OUT);
    assign occupied_d_o = (state_d == ST_OCCUPIED) || (state_d == ST_CONFIRM_OUT);
    assign state_o      = state_q;

endmodule

// File: rtl/slot_event_detector.sv
// Four-slot parking occupancy detector: per-slot debounce FSMs plus lot-level
// aggregation of free slots, full flag and a saturating arrival total.
module slot_event_detector
    import slot_event_detector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SLOTS-1:0]   slot_sensor,
    output logic [NUM_SLOTS-1:0]   car_entry,
    output logic [NUM_SLOTS-1:0]   car_exit,
    output logic [NUM_SLOTS-1:0]   occupied,
    output logic [2:0]             free_count,
    output logic                   lot_full,
    output logic [15:0]            entry_total,
    output logic [2*NUM_SLOTS-1:0] dbg_state_o
);

    logic [NUM_SLOTS-1:0] occupied_d;
    logic [2:0]           occ_cnt_d;
    logic [2:0]           entry_cnt;
    logic [16:0]          total_sum;
    logic [2:0]           free_count_q, free_count_d;
    logic                 lot_full_q, lot_full_d;
    logic [15:0]          entry_total_q, entry_total_d;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        slot_debounce_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .sensor_i     (slot_sensor[g]),
            .entry_o      (car_entry[g]),
            .exit_o       (car_exit[g]),
            .occupied_o   (occupied[g]),
            .occupied_d_o (occupied_d[g]),
            .state_o      (dbg_state_o[2*g +: 2])
        );
    end

    // Built from next-state occupancy so the registered totals line up with occupied.
    always_comb begin
        occ_cnt_d    = popcount4(occupied_d);
        free_count_d = 3'(NUM_SLOTS) - occ_cnt_d;
        lot_full_d   = (occ_cnt_d == 3'(NUM_SLOTS));
        entry_cnt    = popcount4(car_entry);
        total_sum    = {1'b0, entry_total_q} + {14'd0, entry_cnt};
        entry_total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_count_q  <= 3'(NUM_SLOTS);
            lot_full_q    <= 1'b0;
            entry_total_q <= 16'd0;
        end else begin
            free_count_q  <= free_count_d;
            lot_full_q    <= lot_full_d;
            entry_total_q <= entry_total_d;
        end
    end

    assign free_count  = free_count_q;
    assign lot_full    = lot_full_q;
    assign entry_total = entry_total_q;

endmodule

// File: tb/tb_slot_event_detector.sv
// Directed bench for slot_event_detector: debounce timing, glitch rejection,
// simultaneous events, reset abort and entry_total saturation.
`timescale 1ns/1ps
module tb_slot_event_detector;
    import slot_event_detector_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    slot_event_detector_if a_if ();
    slot_event_detector_if b_if ();

    slot_event_detector #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .slot_sensor (a_if.slot_sensor),
        .car_entry   (a_if.car_entry),
        .car_exit    (a_if.car_exit),
        .occupied    (a_if.occupied),
        .free_count  (a_if.free_count),
        .lot_full    (a_if.lot_full),
        .entry_total (a_if.entry_total),
        .dbg_state_o (a_if.dbg_state)
    );

    // Short debounce instance so the saturation run stays short.
    slot_event_detector #(.DEBOUNCE_CYCLES(2), .CNT_W(8)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .slot_sensor (b_if.slot_sensor),
        .car_entry   (b_if.car_entry),
        .car_exit    (b_if.car_exit),
        .occupied    (b_if.occupied),
        .free_count  (b_if.free_count),
        .lot_full    (b_if.lot_full),
        .entry_total (b_if.entry_total),
        .dbg_state_o (b_if.dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_if.slot_sensor = 4'b0000;
        b_if.slot_sensor = 4'b0000;
        reset = 1'b0;
        step(2);
        chk("rst_entry", 32'(a_if.car_entry), 32'h0);
        chk("rst_exit", 32'(a_if.car_exit), 32'h0);
        chk("rst_occupied", 32'(a_if.occupied), 32'h0);
        chk("rst_free", 32'(a_if.free_count), 32'd4);
        chk("rst_full", 32'(a_if.lot_full), 32'd0);
        chk("rst_total", 32'(a_if.entry_total), 32'd0);
        chk("rst_state", 32'(a_if.dbg_state), 32'h0);
        reset = 1'b1;
        step(2);

        // Stable arrival on slot 0: pulse 6 clocks after the raw edge.
        a_if.slot_sensor = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk("s0_entry_early", 32'(a_if.car_entry), 32'h0);
        end
        step(1);
        chk("s0_entry", 32'(a_if.car_entry), 32'h1);
        chk("s0_occupied", 32'(a_if.occupied), 32'h1);
        chk("s0_free", 32'(a_if.free_count), 32'd3);
        chk("s0_exit", 32'(a_if.car_exit), 32'h0);
        step(1);
        chk("s0_entry_once", 32'(a_if.car_entry), 32'h0);
        chk("s0_total", 32'(a_if.entry_total), 32'd1);

        // Three-clock blip on slot 2 is one sample short of confirmation.
        a_if.slot_sensor = 4'b0101;
        step(3);
        a_if.slot_sensor = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("s2_glitch_entry", 32'(a_if.car_entry), 32'h0);
        end
        chk("s2_glitch_occ", 32'(a_if.occupied), 32'h1);

        a_if.slot_sensor = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk("s0_exit_early", 32'(a_if.car_exit), 32'h0);
        end
        step(1);
        chk("s0_exit", 32'(a_if.car_exit), 32'h1);
        chk("s0_occ_clear", 32'(a_if.occupied), 32'h0);
        chk("s0_free_back", 32'(a_if.free_count), 32'd4);
        step(1);

        // Slot 1: short dropout is absorbed, a permanent one is reported.
        a_if.slot_sensor = 4'b0010;
        step(6);
        chk("s1_entry", 32'(a_if.car_entry), 32'h2);
        chk("s1_free", 32'(a_if.free_count), 32'd3);
        step(1);
        a_if.slot_sensor = 4'b0000;
        step(2);
        a_if.slot_sensor = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("s1_dropout_exit", 32'(a_if.car_exit), 32'h0);
        end
        chk("s1_dropout_occ", 32'(a_if.occupied), 32'h2);
        a_if.slot_sensor = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk("s1_exit_early", 32'(a_if.car_exit), 32'h0);
        end
        step(1);
        chk("s1_exit", 32'(a_if.car_exit), 32'h2);
        chk("s1_free_back", 32'(a_if.free_count), 32'd4);
        step(1);
        chk("s1_exit_once", 32'(a_if.car_exit), 32'h0);
        chk("s1_total", 32'(a_if.entry_total), 32'd2);

        // All four slots arrive together.
        a_if.slot_sensor = 4'b1111;
        step(5);
        chk("all_entry_early", 32'(a_if.car_entry), 32'h0);
        step(1);
        chk("all_entry", 32'(a_if.car_entry), 32'hF);
        chk("all_full", 32'(a_if.lot_full), 32'd1);
        chk("all_free", 32'(a_if.free_count), 32'd0);
        chk("all_occ", 32'(a_if.occupied), 32'hF);
        step(1);
        chk("all_total", 32'(a_if.entry_total), 32'd6);
        a_if.slot_sensor = 4'b0000;
        step(6);
        chk("all_exit", 32'(a_if.car_exit), 32'hF);
        chk("all_exit_entry", 32'(a_if.car_entry), 32'h0);
        chk("all_free_back", 32'(a_if.free_count), 32'd4);
        chk("all_not_full", 32'(a_if.lot_full), 32'd0);
        step(1);

        // Reset two clocks into CONFIRM_IN on slot 3.
        a_if.slot_sensor = 4'b1000;
        step(4);
        chk("rc_state_ci", 32'(a_if.dbg_state), 32'h40);
        reset = 1'b0;
        #1;
        chk("rc_entry", 32'(a_if.car_entry), 32'h0);
        chk("rc_occ", 32'(a_if.occupied), 32'h0);
        chk("rc_free", 32'(a_if.free_count), 32'd4);
        chk("rc_full", 32'(a_if.lot_full), 32'd0);
        chk("rc_total", 32'(a_if.entry_total), 32'd0);
        chk("rc_state", 32'(a_if.dbg_state), 32'h0);
        step(2);
        chk("rc_held_entry", 32'(a_if.car_entry), 32'h0);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk("rc_entry_early", 32'(a_if.car_entry), 32'h0);
        end
        step(1);
        chk("rc_entry_after", 32'(a_if.car_entry), 32'h8);
        chk("rc_occ_after", 32'(a_if.occupied), 32'h8);
        step(1);
        chk("rc_total_after", 32'(a_if.entry_total), 32'd1);

        // Saturation: 16383 rounds of four entries, then two more reach FFFE.
        for (int r = 0; r < 16383; r++) begin
            b_if.slot_sensor = 4'b1111;
            step(2);
            b_if.slot_sensor = 4'b0000;
            step(2);
        end
        step(6);
        chk("sat_fffc", 32'(b_if.entry_total), 32'hFFFC);
        b_if.slot_sensor = 4'b0011;
        step(2);
        b_if.slot_sensor = 4'b0000;
        step(6);
        chk("sat_fffe", 32'(b_if.entry_total), 32'hFFFE);
        b_if.slot_sensor = 4'b1100;
        step(2);
        b_if.slot_sensor = 4'b0000;
        step(2);
        chk("sat_pair_entry", 32'(b_if.car_entry), 32'hC);
        step(1);
        chk("sat_ffff", 32'(b_if.entry_total), 32'hFFFF);
        step(6);
        b_if.slot_sensor = 4'b0001;
        step(2);
        b_if.slot_sensor = 4'b0000;
        step(6);
        chk("sat_hold", 32'(b_if.entry_total), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_event_detector.md
SLOT_EVENT_DETECTOR -- requirements
Module: slot_event_detector

Interface
- REQ-001: The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the consecutive synchronized samples required to confirm a sensor change (legal range 2..255).
- REQ-002: The block SHALL have parameter CNT_W, default 8, meaning the width of each per-slot debounce counter.
- REQ-003: The block SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
- REQ-004: The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
- REQ-005: The block SHALL have port slot_sensor, input, 4 bits, raw asynchronous occupancy sensors, one per slot (1 = car detected).
- REQ-006: The block SHALL have port car_entry, output, 4 bits, one-cycle pulse per slot on confirmed arrival.
- REQ-007: The block SHALL have port car_exit, output, 4 bits, one-cycle pulse per slot on confirmed departure.
- REQ-008: The block SHALL have port occupied, output, 4 bits, debounced occupancy state per slot.
- REQ-009: The block SHALL have port free_count, output, 3 bits, number of slots not occupied (0..4).
- REQ-010: The block SHALL have port lot_full, output, 1 bit, high when free_count equals 0.
- REQ-011: The block SHALL have port entry_total, output, 16 bits, saturating count of confirmed arrivals since reset.

Function
- REQ-012: Each slot_sensor bit SHALL pass through a 2-flop synchronizer before use; only the synchronized value (s_sync) is observed.
- REQ-013: Each slot SHALL run an independent FSM with states EMPTY, CONFIRM_IN, OCCUPIED and CONFIRM_OUT.
- REQ-014: EMPTY SHALL go to CONFIRM_IN with counter := 1 when s_sync = 1; otherwise it stays in EMPTY.
- REQ-015: In CONFIRM_IN, s_sync = 0 SHALL return the FSM to EMPTY with counter := 0 and no pulse.
- REQ-016: In CONFIRM_IN, s_sync = 1 with counter = DEBOUNCE_CYCLES-1 SHALL move the FSM to OCCUPIED and assert car_entry[i] for exactly that next cycle; otherwise the counter increments.
- REQ-017: OCCUPIED SHALL go to CONFIRM_OUT with counter := 1 when s_sync = 0.
- REQ-018: CONFIRM_OUT SHALL mirror CONFIRM_IN with s_sync polarity inverted: a glitch returns to OCCUPIED, and confirmation goes to EMPTY with a one-cycle car_exit[i] pulse.
- REQ-019: Latency from a stable raw sensor edge to the corresponding pulse SHALL be DEBOUNCE_CYCLES+2 clocks.
- REQ-020: Pulses SHALL be registered outputs, never held longer than one cycle, and car_entry[i] and car_exit[i] SHALL never be high together.
- REQ-021: occupied[i] SHALL be 1 in the states OCCUPIED and CONFIRM_OUT, and 0 in EMPTY and CONFIRM_IN; it changes in the same cycle as the pulse.
- REQ-022: free_count SHALL equal 4 minus popcount(occupied), registered and consistent with occupied in the same cycle.
- REQ-023: entry_total SHALL add popcount(car_entry) each cycle, with multiple simultaneous entries counted fully, and SHALL saturate at 16'hFFFF without wrap.
- REQ-024: Simultaneous events on different slots SHALL be handled independently in the same cycle.
- REQ-025: Counters SHALL never exceed DEBOUNCE_CYCLES-1, and no arithmetic SHALL overflow CNT_W.

Reset
- REQ-026: While reset = 0, all FSMs SHALL be EMPTY, counters 0, synchronizers 0, car_entry = car_exit = 4'b0, occupied = 4'b0, free_count = 3'd4, lot_full = 0, and entry_total = 0.
- REQ-027: Reset asserted mid-confirmation SHALL abort the confirmation with no pulse emitted.
- REQ-028: After reset release, a car already present SHALL be reported through the normal CONFIRM_IN path.

Structure
- REQ-029: A shared package SHALL hold the slot state encoding (2-bit enum), NUM_SLOTS = 4, and the default DEBOUNCE_CYCLES.
- REQ-030: The block SHALL instantiate a sub-module slot_debounce_fsm four times; each instance contains the synchronizer, the counter, the FSM and the pulse registers for one slot.
- REQ-031: Aggregation logic (free_count, lot_full, entry_total) SHALL reside in the top level.

Verification (DEBOUNCE_CYCLES = 4)
- REQ-032: Hold slot_sensor = 4'b0001 stable -> car_entry = 4'b0001 for exactly 1 cycle, 6 clocks after the edge; occupied = 4'b0001; free_count = 3.
- REQ-033: Pulse slot_sensor[2] high for 3 clocks only -> no car_entry, and occupied[2] stays 0.
- REQ-034: With slot 1 occupied, drop its sensor for 2 clocks, then restore -> no car_exit; then drop it permanently -> car_exit = 4'b0010 after 6 clocks and free_count back to 4.
- REQ-035: Raise all four sensors in the same cycle -> car_entry = 4'b1111 in one cycle, entry_total += 4, lot_full = 1, free_count = 0.
- REQ-036: Assert reset low 2 clocks into CONFIRM_IN -> no pulse, and all outputs take their reset values; after release with the sensor still high -> entry pulse 6 clocks later.
- REQ-037: Preload entry_total to 16'hFFFE via repeated cycles, then trigger 2 simultaneous entries -> entry_total = 16'hFFFF.
